jls_byte_stuffer: RTL and testbench
===================================

JLS_BYTE_STUFFER -- requirements
Module: jls_byte_stuffer

Interface
REQ-001 SHALL have port clk  input  1  sole clock, rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high; clears all state.
REQ-003 SHALL have port en_in  input  1  word strobe; word_in is valid this cycle.
REQ-004 SHALL have port word_in  input  32  packed code bits, MSB first, all 32 valid.
REQ-005 SHALL have port flush  input  1  end-of-scan pulse; flush_word/flush_len are valid this cycle.
REQ-006 SHALL have port flush_word  input  32  final partial bits, MSB-aligned.
REQ-007 SHALL have port flush_len  input  6  valid bits in flush_word, 0..31.
REQ-008 SHALL have port in_ready  output  1  block accepts en_in/flush this cycle.
REQ-009 SHALL have port byte_out  output  8  stuffed output byte.
REQ-010 SHALL have port byte_valid  output  1  byte_out is valid.
REQ-011 SHALL have port byte_ready  input  1  downstream accepts byte; transfer = byte_valid & byte_ready.
REQ-012 SHALL have port done  output  1  one-cycle pulse after the last byte of a scan transfers.

Function
REQ-013 SHALL hold a 64-bit MSB-aligned bit buffer with a 7-bit count, 0..64.
REQ-014 SHALL drive in_ready=1 only in state RUN with count<=32.
REQ-015 SHALL ignore en_in and flush when in_ready=0, and SHALL ignore en_in when flush is also high; flush wins.
REQ-016 SHALL append an accepted word at bit position count; count+=32.
REQ-017 SHALL append an accepted flush_word's top flush_len bits the same way, then enter state DRAIN.
REQ-018 SHALL set need=7 if the previously emitted byte was 0xFF, else need=8.
REQ-019 SHALL form the byte as {1'b0, 7 bits} when need=7, else as the next 8 bits.
REQ-020 SHALL load byte_out when the output register is empty or transferring and count>=need; count-=need.
REQ-021 SHALL allow append and extraction in the same cycle; count'=count+appended-need.
REQ-022 SHALL make the first byte available with byte_valid=1 on the cycle after the word is accepted.
REQ-023 SHALL hold byte_out and byte_valid stable while byte_valid=1 and byte_ready=0.
REQ-024 SHALL implement states RUN, DRAIN, TAIL and DONE.
REQ-025 In DRAIN, SHALL keep extracting while count>=need.
REQ-026 In DRAIN, when 0<count<need, SHALL emit the remaining bits zero-padded to a full byte under the same need rule; count=0.
REQ-027 In DRAIN, when count=0, SHALL go to TAIL.
REQ-028 In TAIL, if the last emitted byte was 0xFF, SHALL emit 0x00; then go to DONE.
REQ-029 In DONE, once the output register is empty, SHALL pulse done for 1 cycle and return to RUN.
REQ-030 On return to RUN, SHALL clear the last-byte-FF flag.
REQ-031 SHALL never let count exceed 64; this is guaranteed by REQ-014.

Reset
REQ-032 On reset, SHALL set byte_out=0x00, byte_valid=0, done=0, count=0, FF flag=0 and state RUN.
REQ-033 SHALL assert in_ready=1 in the first cycle after reset releases.
REQ-034 Reset mid-scan SHALL discard buffered bits and any pending byte without emitting them.

Verification
REQ-035 Reset: assert reset with traffic in flight -> byte_valid=0 and in_ready=0 are not required; after release, in_ready=1 and byte_out=0x00.
REQ-036 Plain: word 0x12345678, then flush len 0, byte_ready=1 -> bytes 12,34,56,78, then done pulse.
REQ-037 Stuffing: word 0xFFFFFFFF, then flush len 0 -> bytes FF,7F,FF,7F,C0, then done.
REQ-038 Partial flush: word 0x000000FF, then flush_word 0xA0000000 with len 3 -> bytes 00,00,00,FF,50, then done.
REQ-039 Terminal FF: flush_word 0xFF000000 with len 8 only -> bytes FF,00, then done.
REQ-040 Backpressure: hold byte_ready=0 for 3 cycles with byte_valid=1 -> byte_out is unchanged; in_ready drops once count>32 and no word is lost.

Source files
------------

// File: rtl/jls_byte_stuffer.sv
// jls_byte_stuffer: packs 32-bit code words into bytes and applies JPEG-LS
// marker stuffing. After any 0xFF byte the next byte carries only 7 data bits
// and has a forced-zero MSB.
// Ports:
//   clk, reset               clock and asynchronous active-high reset
//   en_in, word_in           32-bit code word strobe and data
//   flush, flush_word/len    end-of-scan strobe with the final partial bits
//   in_ready                 the block accepts en_in/flush this cycle
//   byte_out, byte_valid     stuffed output byte and its valid flag
//   byte_ready               downstream accepts the byte
//   done                     one-cycle pulse after the last byte of a scan
module jls_byte_stuffer (
   input  logic        clk,
   input  logic        reset,
   input  logic        en_in,
   input  logic [31:0] word_in,
   input  logic        flush,
   input  logic [31:0] flush_word,
   input  logic [5:0]  flush_len,
   output logic        in_ready,
   output logic [7:0]  byte_out,
   output logic        byte_valid,
   input  logic        byte_ready,
   output logic        done
);

   localparam int unsigned BUF_W  = 64;
   localparam int unsigned CNT_W  = 7;
   localparam int unsigned WORD_W = 32;

   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_TAIL, ST_DONE} state_t;

   state_t             state_q, state_d;
   logic [BUF_W-1:0]   buf_q, buf_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               last_ff_q, last_ff_d;
   logic [7:0]         byte_q, byte_d;
   logic               valid_q, valid_d;
   logic               done_q, done_d;
   logic               in_ready_q, in_ready_d;

   logic               accept_word;
   logic               accept_flush;
   logic [5:0]         flen;
   logic [WORD_W-1:0]  flush_mask;
   logic [WORD_W-1:0]  app_bits;
   logic [CNT_W-1:0]   app_len;
   logic [BUF_W-1:0]   comb_buf;
   logic [CNT_W-1:0]   comb_cnt;
   logic [CNT_W-1:0]   need;
   logic [7:0]         byte_cand;
   logic               load_ok;

   // Next-state, buffer and output-register logic
   always_comb begin
      state_d    = state_q;
      buf_d      = buf_q;
      count_d    = count_q;
      last_ff_d  = last_ff_q;
      byte_d     = byte_q;
      valid_d    = valid_q;
      done_d     = 1'b0;
      in_ready_d = in_ready_q;

      accept_flush = in_ready_q & flush;
      accept_word  = in_ready_q & en_in & ~flush;

      // Lengths above 32 are clamped so the buffer can never overflow
      flen       = (flush_len > 6'd32) ? 6'd32 : flush_len;
      flush_mask = ~(32'hFFFF_FFFF >> flen);

      app_bits = '0;
      app_len  = '0;
      if (accept_word) begin
         app_bits = word_in;
         app_len  = CNT_W'(WORD_W);
      end else if (accept_flush) begin
         app_bits = flush_word & flush_mask;
         app_len  = CNT_W'(flen);
      end

      // Bits below count are always zero, so appending is a plain OR
      comb_buf = buf_q | ({app_bits, 32'h0} >> count_q);
      comb_cnt = count_q + app_len;

      need      = last_ff_q ? CNT_W'(7) : CNT_W'(8);
      byte_cand = last_ff_q ? {1'b0, comb_buf[63:57]} : comb_buf[63:56];
      load_ok   = ~valid_q | byte_ready;

      if (valid_q && byte_ready) begin
         valid_d = 1'b0;
      end

      case (state_q)
         ST_RUN: begin
            buf_d   = comb_buf;
            count_d = comb_cnt;
            if (accept_flush) begin
               state_d = ST_DRAIN;
            end
            if (load_ok && (comb_cnt >= need)) begin
               byte_d    = byte_cand;
               valid_d   = 1'b1;
               last_ff_d = (byte_cand == 8'hFF);
               buf_d     = comb_buf << need;
               count_d   = comb_cnt - need;
            end
         end
         ST_DRAIN: begin
            if (count_q == '0) begin
               state_d = ST_TAIL;
            end else if (load_ok) begin
               // A short remainder goes out zero-padded via the same byte former
               byte_d    = byte_cand;
               valid_d   = 1'b1;
               last_ff_d = (byte_cand == 8'hFF);
               if (count_q >= need) begin
                  buf_d   = buf_q << need;
                  count_d = count_q - need;
               end else begin
                  buf_d   = '0;
                  count_d = '0;
               end
            end
         end
         ST_TAIL: begin
            // A scan may not end on 0xFF: close it with a stuffed zero byte
            if (!last_ff_q) begin
               state_d = ST_DONE;
            end else if (load_ok) begin
               byte_d    = 8'h00;
               valid_d   = 1'b1;
               last_ff_d = 1'b0;
               state_d   = ST_DONE;
            end
         end
         ST_DONE: begin
            if (!valid_q) begin
               done_d    = 1'b1;
               last_ff_d = 1'b0;
               state_d   = ST_RUN;
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase

      in_ready_d = (state_d == ST_RUN) && (count_d <= CNT_W'(WORD_W));
   end

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_RUN;
         buf_q      <= '0;
         count_q    <= '0;
         last_ff_q  <= 1'b0;
         byte_q     <= 8'h00;
         valid_q    <= 1'b0;
         done_q     <= 1'b0;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         buf_q      <= buf_d;
         count_q    <= count_d;
         last_ff_q  <= last_ff_d;
         byte_q     <= byte_d;
         valid_q    <= valid_d;
         done_q     <= done_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign byte_out   = byte_q;
   assign byte_valid = valid_q;
   assign done       = done_q;

endmodule

// File: tb/tb_jls_byte_stuffer.sv
// Bench for jls_byte_stuffer: a bit-queue reference model produces the
// expected byte stream of each scan; a monitor checks every transfer and done
// pulse against it while byte_ready is randomised or forced.
module tb_jls_byte_stuffer;

   logic        clk;
   logic        reset;
   logic        en_in;
   logic [31:0] word_in;
   logic        flush;
   logic [31:0] flush_word;
   logic [5:0]  flush_len;
   logic        in_ready;
   logic [7:0]  byte_out;
   logic        byte_valid;
   logic        byte_ready;
   logic        done;

   int vectors = 0;
   int miscompares = 0;
   int ready_mode = 2;   // 0 random, 1 forced low, 2 forced high

   logic [31:0] scan_words[$];
   logic [31:0] scan_fw;
   logic [5:0]  scan_fl;
   logic [7:0]  model_bytes[$];
   logic [8:0]  exp_q[$];   // bit 8 set marks the expected done pulse

   logic        hold_pend = 1'b0;
   logic [7:0]  hold_byte = 8'h00;

   jls_byte_stuffer dut (
      .clk        (clk),
      .reset      (reset),
      .en_in      (en_in),
      .word_in    (word_in),
      .flush      (flush),
      .flush_word (flush_word),
      .flush_len  (flush_len),
      .in_ready   (in_ready),
      .byte_out   (byte_out),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
      end
   endtask

   // Reference: stream bits MSB first, 7 or 8 bits per byte, zero-pad the end
   task automatic build_model();
      logic q[$];
      logic prev_ff;
      logic [7:0] b;
      int n;
      model_bytes.delete();
      foreach (scan_words[w])
         for (int i = 31; i >= 0; i--) q.push_back(scan_words[w][i]);
      for (int i = 0; i < int'(scan_fl); i++) q.push_back(scan_fw[31-i]);
      prev_ff = 1'b0;
      while (q.size() > 0) begin
         n = prev_ff ? 7 : 8;
         b = 8'h00;
         for (int i = 0; i < n; i++) begin
            if (q.size() > 0) b = {b[6:0], q.pop_front()};
            else              b = {b[6:0], 1'b0};
         end
         model_bytes.push_back(b);
         prev_ff = (b == 8'hFF);
      end
      if (prev_ff) model_bytes.push_back(8'h00);
   endtask

   task automatic pin_model(input string nm, input int n, input logic [63:0] lit);
      logic [63:0] got;
      build_model();
      got = '0;
      foreach (model_bytes[i]) got = {got[55:0], model_bytes[i]};
      check({nm, "_len"}, 64'(model_bytes.size()), 64'(n));
      check(nm, got, lit);
   endtask

   // byte_ready driver
   initial begin
      byte_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       byte_ready = ($urandom % 4) != 0;
            1:       byte_ready = 1'b0;
            default: byte_ready = 1'b1;
         endcase
      end
   end

   // Output monitor: transfers, done pulses and stall stability
   always @(negedge clk) begin
      if (reset) begin
         hold_pend = 1'b0;
      end else begin
         if (hold_pend) begin
            check("stall_valid", 64'(byte_valid), 64'(1));
            check("stall_byte", 64'(byte_out), 64'(hold_byte));
         end
         hold_pend = byte_valid && !byte_ready;
         hold_byte = byte_out;
         if (byte_valid && byte_ready) begin
            if (exp_q.size() == 0 || exp_q[0][8]) begin
               check("extra_byte", 64'(byte_out), 64'h1FF);
            end else begin
               check("byte", 64'(byte_out), 64'(exp_q[0][7:0]));
               void'(exp_q.pop_front());
            end
         end
         if (done) begin
            if (exp_q.size() > 0 && exp_q[0][8]) begin
               check("done", 64'(done), 64'(1));
               void'(exp_q.pop_front());
            end else begin
               check("early_done", 64'(exp_q.size()), 64'h100);
            end
         end
      end
   end

   // Callers are at posedge+1; returns at posedge+1 after the accepting edge
   task automatic wait_accept(input string nm);
      int t;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) check({nm, "_timeout"}, 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [31:0] w);
      en_in   = 1'b1;
      word_in = w;
      wait_accept("send_word");
      en_in   = 1'b0;
   endtask

   task automatic send_flush(input logic [31:0] fw, input logic [5:0] fl, input logic junk_en);
      flush      = 1'b1;
      flush_word = fw;
      flush_len  = fl;
      en_in      = junk_en;
      word_in    = $urandom;
      wait_accept("send_flush");
      flush = 1'b0;
      en_in = 1'b0;
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (exp_q.size() > 0 && t < 3000) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("drain_left", 64'(exp_q.size()), 64'(0));
      exp_q.delete();
   endtask

   task automatic run_scan(input logic junk_en);
      build_model();
      foreach (model_bytes[i]) exp_q.push_back({1'b0, model_bytes[i]});
      exp_q.push_back(9'h100);
      foreach (scan_words[i]) send_word(scan_words[i]);
      send_flush(scan_fw, scan_fl, junk_en);
      @(negedge clk);
      check("in_ready_drain", 64'(in_ready), 64'(0));
      @(posedge clk);
      #1;
      wait_drain();
   endtask

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      for (int i = 0; i < 4; i++)
         w[8*i +: 8] = (($urandom % 3) == 0) ? 8'hFF : 8'($urandom);
      return w;
   endfunction

   initial begin
      reset = 1'b1; en_in = 1'b0; word_in = '0;
      flush = 1'b0; flush_word = '0; flush_len = '0;

      // Model pins
      scan_words = '{32'h12345678}; scan_fw = 32'h0; scan_fl = 6'd0;
      pin_model("pin_plain", 4, 64'h12345678);
      scan_words = '{32'hFFFFFFFF};
      pin_model("pin_stuff", 5, 64'hFF7FFF7FC0);
      scan_words = '{32'h000000FF}; scan_fw = 32'hA0000000; scan_fl = 6'd3;
      pin_model("pin_partial", 5, 64'h000000FF50);
      scan_words.delete(); scan_fw = 32'hFF000000; scan_fl = 6'd8;
      pin_model("pin_tail", 2, 64'hFF00);

      // Reset state
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'(1));
      check("rst_byte", 64'(byte_out), 64'h00);
      check("rst_valid", 64'(byte_valid), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      @(posedge clk);
      #1;

      // First byte latency then plain scan
      ready_mode = 2;
      @(posedge clk);
      #1;
      scan_words = '{32'h12345678}; scan_fw = 32'h0; scan_fl = 6'd0;
      build_model();
      foreach (model_bytes[i]) exp_q.push_back({1'b0, model_bytes[i]});
      exp_q.push_back(9'h100);
      send_word(32'h12345678);
      @(negedge clk);
      check("first_valid", 64'(byte_valid), 64'(1));
      check("first_byte", 64'(byte_out), 64'h12);
      @(posedge clk);
      #1;
      send_flush(32'h0, 6'd0, 1'b0);
      wait_drain();

      // Directed stuffing, partial and terminal-FF scans
      scan_words = '{32'hFFFFFFFF}; scan_fw = 32'h0; scan_fl = 6'd0;
      run_scan(1'b0);
      scan_words = '{32'h000000FF}; scan_fw = 32'hA0000000; scan_fl = 6'd3;
      run_scan(1'b1);
      scan_words.delete(); scan_fw = 32'hFF000000; scan_fl = 6'd8;
      run_scan(1'b0);

      // Backpressure: stalled output, in_ready drops, nothing lost
      ready_mode = 1;
      @(posedge clk);
      #1;
      scan_words = '{32'hAABBCCDD, 32'h11223344}; scan_fw = 32'h0; scan_fl = 6'd0;
      build_model();
      foreach (model_bytes[i]) exp_q.push_back({1'b0, model_bytes[i]});
      exp_q.push_back(9'h100);
      send_word(32'hAABBCCDD);
      send_word(32'h11223344);
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'(0));
      check("bp_byte", 64'(byte_out), 64'hAA);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;
      ready_mode = 0;
      send_flush(32'h0, 6'd0, 1'b0);
      wait_drain();

      // Reset mid-scan discards everything buffered
      ready_mode = 1;
      @(posedge clk);
      #1;
      send_word(32'hDEADBEEF);
      send_word(32'hFFFFFFFF);
      #2 reset = 1'b1;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("mid_rst_in_ready", 64'(in_ready), 64'(1));
      check("mid_rst_valid", 64'(byte_valid), 64'(0));
      check("mid_rst_byte", 64'(byte_out), 64'h00);
      @(posedge clk);
      #1;
      ready_mode = 0;
      repeat (4) begin
         @(negedge clk);
         check("mid_rst_quiet", 64'(byte_valid), 64'(0));
      end
      @(posedge clk);
      #1;
      scan_words = '{32'h12345678}; scan_fw = 32'h0; scan_fl = 6'd0;
      run_scan(1'b0);

      // Randomised scans
      for (int s = 0; s < 60; s++) begin
         ready_mode = ($urandom % 3 == 0) ? 2 : 0;
         scan_words.delete();
         for (int k = 0; k < int'($urandom % 5); k++) scan_words.push_back(rand_word());
         scan_fw = rand_word();
         scan_fl = 6'($urandom % 32);
         run_scan(1'($urandom % 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
